// File: rtl/frame_update_ctrl_pkg.sv
// Shared constants and types for the tile display path.
// The tile-grid geometry and VGA vertical timing live here so that the
// VGA timing block and the frame update controller agree on them.
package frame_update_ctrl_pkg;

    // Display grid: 640x480 pixels split into 16x16 tiles.
    localparam int TILE_PX       = 16;
    localparam int GRID_W        = 40;
    localparam int GRID_H        = 30;
    localparam int TILES         = GRID_W * GRID_H;

    // VGA vertical timing, in lines.
    localparam int V_DISPLAY     = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_PULSE  = 2;
    localparam int V_BACK_PORCH  = 33;
    localparam int V_TOTAL       = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    // Pending-write entry: {value, tile index}.
    localparam int IDX_W   = 11;
    localparam int ENTRY_W = IDX_W + 1;

    typedef struct packed {
        logic             value;
        logic [IDX_W-1:0] index;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/tile_write_fifo.sv
// Pending tile-write queue: synchronous FIFO with full/empty flags.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (empties the queue)
//   push, din    - write an entry (ignored when full)
//   pop, dout    - drop the head entry (ignored when empty); dout shows the head
//   full, empty  - occupancy flags, decoded from the registered count only
// DEPTH must be a power of two so the pointers wrap naturally.
module tile_write_fifo
    import frame_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A push while full is refused even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/frame_update_ctrl.sv
// Frame update controller: queues tile writes from a requester and applies
// them to the displayed tile bitmap only during vertical blanking, so the
// picture never tears mid-frame. A clear request blanks the whole bitmap at
// the next blanking interval, before any queued writes are applied.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   v_position        - current line from the VGA timing block
//   wr_valid/wr_ready - tile write handshake; wr_index/wr_value carry it
//   clear_req         - single-cycle request to blank all tiles
//   frame_data        - tile bitmap to the VGA data input
//   busy              - queue non-empty or clear pending
//   vblank_start      - one-cycle pulse on entry to vertical blanking
//   index_err         - one-cycle pulse when an out-of-range entry is dropped
//   dbg_state         - controller FSM state, for observation only
// Handshake: a write transfers on a rising edge where wr_valid and wr_ready
// are both high. wr_valid may be raised without waiting for wr_ready, must
// hold its payload until the transfer, and wr_ready never depends on wr_valid.
module frame_update_ctrl
    import frame_update_ctrl_pkg::*;
#(
    parameter int TILES              = frame_update_ctrl_pkg::TILES,
    parameter int FIFO_DEPTH         = 8,
    parameter int V_DISPLAY_INTERVAL = frame_update_ctrl_pkg::V_DISPLAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      v_position,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [10:0]      wr_index,
    input  logic             wr_value,
    input  logic             clear_req,
    output logic [TILES-1:0] frame_data,
    output logic             busy,
    output logic             vblank_start,
    output logic             index_err,
    output state_e           dbg_state
);

    state_e           state_q, state_d;
    logic             clear_pend_q, clear_pend_d;
    logic             vblank_q, vblank;
    logic [TILES-1:0] frame_data_q, frame_data_d;
    logic             index_err_c;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    entry_t           fifo_din, fifo_dout;

    assign vblank    = (32'(v_position) >= V_DISPLAY_INTERVAL);

    // Held low through reset so nothing is accepted into a queue being flushed.
    assign wr_ready  = ~fifo_full & ~reset;
    assign fifo_push = wr_valid & wr_ready;
    assign fifo_din  = '{value: wr_value, index: wr_index};

    tile_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q | clear_req;
        frame_data_d = frame_data_q;
        fifo_pop     = 1'b0;
        index_err_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vblank && clear_pend_q) begin
                    state_d = ST_CLEAR;
                end else if (vblank && !fifo_empty) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_CLEAR: begin
                // Reached only from a blanking line, so vblank_q is high here.
                // A clear_req arriving this cycle is absorbed by this clear.
                frame_data_d = '0;
                clear_pend_d = 1'b0;
                state_d      = fifo_empty ? ST_IDLE : ST_COMMIT;
            end
            ST_COMMIT: begin
                if (!vblank || fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (vblank_q) begin
                    fifo_pop = 1'b1;
                    if (32'(fifo_dout.index) < TILES) begin
                        frame_data_d[fifo_dout.index] = fifo_dout.value;
                    end else begin
                        index_err_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clear_pend_q <= 1'b0;
            vblank_q     <= 1'b0;
            frame_data_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            vblank_q     <= vblank;
            frame_data_q <= frame_data_d;
        end
    end

    assign frame_data   = frame_data_q;
    assign busy         = (~fifo_empty | clear_pend_q) & ~reset;
    assign vblank_start = vblank & ~vblank_q & ~reset;
    assign index_err    = index_err_c & ~reset;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_frame_update_ctrl.sv
// Bench for frame_update_ctrl: directed steps plus randomized writes, checked
// against a frame-level model (bitmap + ordered pending list + clear flag)
// that applies a whole blanking interval at once.
module tb_frame_update_ctrl;
    import frame_update_ctrl_pkg::*;

    localparam int T  = 1200;
    localparam int FD = 8;
    localparam int VD = 480;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [10:0]  v_position = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [10:0]  wr_index = '0;
    logic         wr_value = 1'b0;
    logic         clear_req = 1'b0;
    logic [T-1:0] frame_data;
    logic         busy;
    logic         vblank_start;
    logic         index_err;
    state_e       dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model
    logic [11:0]  exp_q[$];
    logic [T-1:0] model_frame = '0;
    bit           model_clear = 1'b0;
    int           exp_err = 0;

    always #10 clk = ~clk;

    frame_update_ctrl #(
        .TILES              (T),
        .FIFO_DEPTH         (FD),
        .V_DISPLAY_INTERVAL (VD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .v_position   (v_position),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_index     (wr_index),
        .wr_value     (wr_value),
        .clear_req    (clear_req),
        .frame_data   (frame_data),
        .busy         (busy),
        .vblank_start (vblank_start),
        .index_err    (index_err),
        .dbg_state    (dbg_state)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag);
        int first;
        vectors++;
        assert (frame_data === model_frame) else begin
            miscompares++;
            first = -1;
            for (int i = 0; i < T; i++) begin
                if (first < 0 && frame_data[i] !== model_frame[i]) first = i;
            end
            $error("FAIL %s: frame_data tile %0d got %0b, expected %0b (ones got %0d expected %0d)",
                   tag, first, frame_data[first], model_frame[first],
                   $countones(frame_data), $countones(model_frame));
        end
    endtask

    // Blanking-interval effect: clear first, then every pending write in order.
    function automatic void model_apply();
        logic [11:0] e;
        exp_err = 0;
        if (model_clear) model_frame = '0;
        model_clear = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (int'(e[10:0]) < T) model_frame[e[10:0]] = e[11];
            else exp_err++;
        end
    endfunction

    task automatic do_write(input logic [10:0] idx, input logic val);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_index = idx;
        wr_value = val;
        #1;
        while (!wr_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("wr_accept_timeout", 32'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        exp_q.push_back({val, idx});
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        model_clear = 1'b1;
    endtask

    task automatic vblank_pass(input string tag);
        int errs, starts;
        v_position = 11'(VD + $urandom_range(0, 44));
        #1;
        starts = int'(vblank_start);
        errs   = int'(index_err);
        repeat (FD + 12) begin
            step();
            starts += int'(vblank_start);
            errs   += int'(index_err);
        end
        v_position = 11'($urandom_range(0, VD - 1));
        step();
        model_apply();
        chk({tag, "_vblank_start"}, 32'(starts), 1);
        chk({tag, "_index_err"}, 32'(errs), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk_frame({tag, "_frame"});
    endtask

    initial begin
        int n;
        int nw;
        logic [10:0] idx;
        logic val;

        // Reset
        repeat (2) step();
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vblank_start", 32'(vblank_start), 0);
        chk("rst_index_err", 32'(index_err), 0);
        reset = 1'b0;
        step();
        chk("post_rst_wr_ready", 32'(wr_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_index_err", 32'(index_err), 0);
        chk_frame("post_rst_frame");

        // Write held through the display interval, applied right after vblank entry
        v_position = 11'd100;
        do_write(11'd5, 1'b1);
        chk("req037_busy", 32'(busy), 1);
        repeat (3) step();
        chk("req037_hold", 32'(frame_data[5]), 0);
        v_position = 11'd480;
        #1;
        chk("req037_vblank_start", 32'(vblank_start), 1);
        step();
        chk("req037_vblank_start_end", 32'(vblank_start), 0);
        step();
        chk("req037_applied", 32'(frame_data[5]), 1);
        repeat (3) step();
        v_position = 11'd0;
        step();
        model_apply();
        chk_frame("req037_frame");
        chk("req037_busy_end", 32'(busy), 0);

        // Same index twice: the later write wins
        v_position = 11'($urandom_range(0, VD - 1));
        do_write(11'd7, 1'b1);
        do_write(11'd7, 1'b0);
        vblank_pass("req039");
        chk("req039_bit7", 32'(frame_data[7]), 0);

        // Queue fills at eight; the ninth waits for the first pop
        v_position = 11'd50;
        for (int k = 0; k < FD; k++) begin
            do_write(11'($urandom_range(0, T - 1)), 1'($urandom_range(0, 1)));
        end
        chk("req038_full", 32'(wr_ready), 0);
        idx = 11'($urandom_range(0, T - 1));
        val = 1'($urandom_range(0, 1));
        wr_valid = 1'b1;
        wr_index = idx;
        wr_value = val;
        repeat (3) step();
        chk("req038_hold", 32'(wr_ready), 0);
        chk_frame("req038_display_hold");
        v_position = 11'd480;
        #1;
        n = 0;
        while (!wr_ready && n < 20) begin
            step();
            n++;
        end
        chk("req038_wait", 32'(n), 2);
        step();
        wr_valid = 1'b0;
        exp_q.push_back({val, idx});
        repeat (FD + 12) step();
        v_position = 11'd100;
        step();
        model_apply();
        chk_frame("req038_frame");
        chk("req038_busy", 32'(busy), 0);

        // All ones, then clear plus one write
        v_position = 11'd480;
        for (int i = 0; i < T; i++) do_write(11'(i), 1'b1);
        repeat (FD + 4) step();
        v_position = 11'd100;
        step();
        model_apply();
        chk_frame("req040_ones");
        v_position = 11'd200;
        pulse_clear();
        chk("req040_busy", 32'(busy), 1);
        do_write(11'd3, 1'b1);
        pulse_clear();
        chk_frame("req040_display_hold");
        vblank_pass("req040");
        chk("req040_popcount", 32'($countones(frame_data)), 1);
        chk("req040_bit3", 32'(frame_data[3]), 1);

        // Out-of-range index is dropped with a single error pulse
        v_position = 11'd100;
        do_write(11'd1200, 1'b1);
        vblank_pass("req041");

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(1, 6);
            v_position = 11'($urandom_range(0, VD - 1));
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 9) == 0) idx = 11'($urandom_range(T, T + 10));
                else idx = 11'($urandom_range(0, T - 1));
                do_write(idx, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) pulse_clear();
            end
            chk("rnd_busy", 32'(busy), 1);
            chk_frame("rnd_display_hold");
            vblank_pass("rnd");
        end

        // Reset in the middle of a commit
        v_position = 11'd100;
        for (int k = 0; k < 5; k++) do_write(11'($urandom_range(0, T - 1)), 1'b1);
        v_position = 11'd480;
        step();
        step();
        chk("req042_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        v_position = 11'd0;
        step();
        exp_q.delete();
        model_frame = '0;
        model_clear = 1'b0;
        chk_frame("req042_frame_rst");
        chk("req042_busy_rst", 32'(busy), 0);
        chk("req042_wr_ready_rst", 32'(wr_ready), 0);
        reset = 1'b0;
        step();
        chk("req042_wr_ready", 32'(wr_ready), 1);
        chk("req042_busy", 32'(busy), 0);
        chk_frame("req042_frame");
        vblank_pass("req042_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
